// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_ctrl_pkg
//  Description : Shared types and encodings for the LC-3 sequencing controller.
//                Optional feature macro used by the controller: LC3_CTRL_PERF_EN
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXECUTE   = 4'd3,
        MEM_IND   = 4'd4,
        MEM_RD    = 4'd5,
        MEM_WR    = 4'd6,
        WRITEBACK = 4'd7,
        UPDATE_PC = 4'd8
    } state_t;

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;

    localparam logic [1:0] c_MEMST_RD   = 2'd0;
    localparam logic [1:0] c_MEMST_IND  = 2'd1;
    localparam logic [1:0] c_MEMST_WR   = 2'd2;
    localparam logic [1:0] c_MEMST_IDLE = 2'd3;

    function automatic logic [1:0] mem_state_of(input state_t s);
        case (s)
            MEM_RD:  return c_MEMST_RD;
            MEM_IND: return c_MEMST_IND;
            MEM_WR:  return c_MEMST_WR;
            default: return c_MEMST_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_op_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_op_classifier
//  Description : Combinational LC-3 opcode classification for the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_op_classifier
    import lc3_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_ind,
    output logic       is_ctl
);

    // LDI/STI also flag is_ld/is_st so the indirect phase knows where to go next
    always_comb begin
        is_alu = 1'b0;
        is_ld  = 1'b0;
        is_st  = 1'b0;
        is_ind = 1'b0;
        is_ctl = 1'b0;
        case (opcode)
            c_OP_ADD, c_OP_AND, c_OP_NOT, c_OP_LEA: is_alu = 1'b1;
            c_OP_LD,  c_OP_LDR:                     is_ld  = 1'b1;
            c_OP_ST,  c_OP_STR:                     is_st  = 1'b1;
            c_OP_LDI: begin
                is_ind = 1'b1;
                is_ld  = 1'b1;
            end
            c_OP_STI: begin
                is_ind = 1'b1;
                is_st  = 1'b1;
            end
            c_OP_BR,  c_OP_JMP:                     is_ctl = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lc3_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_seq_controller
//  Description : LC-3 multi-cycle sequencer; one instruction in flight, outputs
//                are registered decodes of the state. Optional retired-
//                instruction counter enabled by LC3_CTRL_PERF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_seq_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int PSR_W      = 3,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  complete_instr,
    input  logic                  complete_data,
    input  logic [INSTR_W-1:0]    IR,
    input  logic [PSR_W-1:0]      psr,
    output logic                  enable_fetch,
    output logic                  enable_decode,
    output logic                  enable_execute,
    output logic                  enable_writeback,
    output logic                  enable_updatePC,
    output logic                  br_taken,
    output logic [1:0]            mem_state
`ifdef LC3_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] instr_retired
`endif
);

    // Only the opcode and the branch condition field are needed after EXECUTE
    localparam int c_IRQ_W = 4 + PSR_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IRQ_W-1:0] r_ir_q;
    logic [c_IRQ_W-1:0] w_ir_sel;
    logic [3:0]         w_opcode;
    logic [PSR_W-1:0]   w_cond;
    logic               w_is_alu;
    logic               w_is_ld;
    logic               w_is_st;
    logic               w_is_ind;
    logic               w_is_ctl;
    logic               w_unused_ir;

    logic               w_en_fetch;
    logic               w_en_decode;
    logic               w_en_execute;
    logic               w_en_writeback;
    logic               w_en_updatepc;
    logic               w_br_next;
    logic [1:0]         w_mem_next;

    // During EXECUTE the value being captured is used directly so the
    // branch out of EXECUTE sees the same instruction that ir_q will hold.
    assign w_ir_sel    = (r_state == EXECUTE) ? IR[INSTR_W-1 -: c_IRQ_W] : r_ir_q;
    assign w_opcode    = w_ir_sel[c_IRQ_W-1 -: 4];
    assign w_cond      = w_ir_sel[PSR_W-1:0];
    assign w_unused_ir = ^IR[INSTR_W-c_IRQ_W-1:0];

    lc3_op_classifier u_classifier (
        .opcode (w_opcode),
        .is_alu (w_is_alu),
        .is_ld  (w_is_ld),
        .is_st  (w_is_st),
        .is_ind (w_is_ind),
        .is_ctl (w_is_ctl)
    );

    // State register; outputs are registered from the next-state decode so
    // each one is high for exactly the cycles spent in its state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_ir_q           <= '0;
            enable_fetch     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            enable_updatePC  <= 1'b0;
            br_taken         <= 1'b0;
            mem_state        <= c_MEMST_IDLE;
        end else begin
            r_state          <= w_state_next;
            if (r_state == EXECUTE) begin
                r_ir_q <= IR[INSTR_W-1 -: c_IRQ_W];
            end
            enable_fetch     <= w_en_fetch;
            enable_decode    <= w_en_decode;
            enable_execute   <= w_en_execute;
            enable_writeback <= w_en_writeback;
            enable_updatePC  <= w_en_updatepc;
            br_taken         <= w_br_next;
            mem_state        <= w_mem_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      w_state_next = FETCH;
            FETCH:     if (complete_instr) w_state_next = DECODE;
            DECODE:    w_state_next = EXECUTE;
            EXECUTE: begin
                if (w_is_ind)      w_state_next = MEM_IND;
                else if (w_is_ld)  w_state_next = MEM_RD;
                else if (w_is_st)  w_state_next = MEM_WR;
                else if (w_is_alu) w_state_next = WRITEBACK;
                else               w_state_next = UPDATE_PC;
            end
            MEM_IND:   if (complete_data) w_state_next = w_is_ld ? MEM_RD : MEM_WR;
            MEM_RD:    if (complete_data) w_state_next = WRITEBACK;
            MEM_WR:    if (complete_data) w_state_next = UPDATE_PC;
            WRITEBACK: w_state_next = UPDATE_PC;
            UPDATE_PC: w_state_next = FETCH;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_en_fetch     = (w_state_next == FETCH);
        w_en_decode    = (w_state_next == DECODE);
        w_en_execute   = (w_state_next == EXECUTE);
        w_en_writeback = (w_state_next == WRITEBACK);
        w_en_updatepc  = (w_state_next == UPDATE_PC);
        w_mem_next     = mem_state_of(w_state_next);
        w_br_next      = 1'b0;
        if ((w_state_next == UPDATE_PC) && w_is_ctl) begin
            w_br_next = (w_opcode == c_OP_JMP) || (|(psr & w_cond));
        end
    end

`ifdef LC3_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] r_instr_retired;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr_retired <= '0;
        end else if (r_state == UPDATE_PC) begin
            r_instr_retired <= r_instr_retired + 1'b1;
        end
    end

    assign instr_retired = r_instr_retired;
`else
    logic [PERF_CNT_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_seq_controller
//  Description : Table-driven scoreboard bench for lc3_seq_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_seq_controller;

    localparam int c_PW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        complete_instr = 1'b1;
    logic        complete_data  = 1'b1;
    logic [15:0] IR  = 16'h0000;
    logic [2:0]  psr = 3'b000;
    logic        enable_fetch, enable_decode, enable_execute;
    logic        enable_writeback, enable_updatePC, br_taken;
    logic [1:0]  mem_state;
    logic [c_PW-1:0] instr_retired;

`ifdef LC3_CTRL_PERF_EN
    lc3_seq_controller #(.PERF_CNT_W(c_PW)) dut (
        .clock(clock), .reset(reset),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .IR(IR), .psr(psr),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken),
        .mem_state(mem_state), .instr_retired(instr_retired)
    );
`else
    lc3_seq_controller dut (
        .clock(clock), .reset(reset),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .IR(IR), .psr(psr),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken),
        .mem_state(mem_state)
    );
    assign instr_retired = '0;
`endif

    always #5 clock = ~clock;

    // Output word layout: {fetch, decode, execute, writeback, updatePC, br, mem[1:0]}
    localparam logic [7:0] W_IDLE = 8'b00000_0_11;
    localparam logic [7:0] W_F    = 8'b10000_0_11;
    localparam logic [7:0] W_D    = 8'b01000_0_11;
    localparam logic [7:0] W_E    = 8'b00100_0_11;
    localparam logic [7:0] W_W    = 8'b00010_0_11;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  psr;
        int          iwait;
        int          dwait;
        logic [1:0]  m1;
        logic [1:0]  m2;
        bit          wb;
        bit          br;
    } vec_t;

    vec_t       tbl[18];
    logic [7:0] sb_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         iwait   = 0;
    int         dwait   = 0;
    logic [c_PW-1:0] exp_ret = '0;

    function automatic logic [7:0] out_word();
        return {enable_fetch, enable_decode, enable_execute, enable_writeback,
                enable_updatePC, br_taken, mem_state};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Memory responders: hold complete_* low for iwait/dwait cycles of each phase
    initial begin
        int         fcnt = 0;
        int         dcnt = 0;
        logic       prev_f = 1'b0;
        logic [1:0] prev_m = 2'd3;
        forever begin
            @(negedge clock);
            if (enable_fetch && prev_f) fcnt++; else fcnt = 0;
            if (mem_state == prev_m) dcnt++; else dcnt = 0;
            prev_f = enable_fetch;
            prev_m = mem_state;
            complete_instr = !(enable_fetch && (fcnt < iwait));
            complete_data  = (mem_state == 2'd3) ? 1'b1 : (dcnt >= dwait);
        end
    end

    task automatic run_vec(input vec_t v, input int idx, input int skip);
        logic [7:0] exp_w;
        IR = v.ir; psr = v.psr; iwait = v.iwait; dwait = v.dwait;
        for (int i = 0; i <= v.iwait; i++) sb_q.push_back(W_F);
        sb_q.push_back(W_D);
        sb_q.push_back(W_E);
        if (v.m1 != 2'd3) for (int i = 0; i <= v.dwait; i++) sb_q.push_back({6'b0, v.m1});
        if (v.m2 != 2'd3) for (int i = 0; i <= v.dwait; i++) sb_q.push_back({6'b0, v.m2});
        if (v.wb) sb_q.push_back(W_W);
        sb_q.push_back({5'b00001, v.br, 2'b11});
        for (int i = 0; i < skip; i++) void'(sb_q.pop_front());
        for (int c = 0; sb_q.size() > 0; c++) begin
            @(posedge clock); #1;
            exp_w = sb_q.pop_front();
            check($sformatf("vec%0d_cyc%0d", idx, c), {24'b0, out_word()}, {24'b0, exp_w});
`ifdef LC3_CTRL_PERF_EN
            if (exp_w[3]) begin
                check($sformatf("vec%0d_retired", idx), {28'b0, instr_retired}, {28'b0, exp_ret});
                exp_ret++;
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        //         ir       psr    iw dw m1    m2    wb br
        tbl[0]  = '{16'h1261, 3'b010, 0, 0, 2'd3, 2'd3, 1, 0}; // ADD
        tbl[1]  = '{16'h2205, 3'b010, 0, 3, 2'd0, 2'd3, 1, 0}; // LD, data late
        tbl[2]  = '{16'hA205, 3'b010, 0, 0, 2'd1, 2'd0, 1, 0}; // LDI
        tbl[3]  = '{16'hB205, 3'b010, 0, 0, 2'd1, 2'd2, 0, 0}; // STI
        tbl[4]  = '{16'h0A03, 3'b100, 0, 0, 2'd3, 2'd3, 0, 1}; // BRnp, N set
        tbl[5]  = '{16'h0A03, 3'b010, 0, 0, 2'd3, 2'd3, 0, 0}; // BRnp, Z set
        tbl[6]  = '{16'hC1C0, 3'b000, 0, 0, 2'd3, 2'd3, 0, 1}; // JMP
        tbl[7]  = '{16'h3205, 3'b010, 2, 1, 2'd2, 2'd3, 0, 0}; // ST, fetch late
        tbl[8]  = '{16'h5261, 3'b001, 0, 0, 2'd3, 2'd3, 1, 0}; // AND
        tbl[9]  = '{16'hF025, 3'b111, 0, 0, 2'd3, 2'd3, 0, 0}; // TRAP -> NOP
        tbl[10] = '{16'h6205, 3'b010, 0, 2, 2'd0, 2'd3, 1, 0}; // LDR
        tbl[11] = '{16'h7205, 3'b010, 1, 0, 2'd2, 2'd3, 0, 0}; // STR
        tbl[12] = '{16'h927F, 3'b010, 0, 0, 2'd3, 2'd3, 1, 0}; // NOT
        tbl[13] = '{16'hE205, 3'b010, 0, 0, 2'd3, 2'd3, 1, 0}; // LEA
        tbl[14] = '{16'h0E00, 3'b001, 0, 0, 2'd3, 2'd3, 0, 1}; // BRnzp
        tbl[15] = '{16'h0000, 3'b111, 0, 0, 2'd3, 2'd3, 0, 0}; // BR never
        tbl[16] = '{16'hA205, 3'b010, 0, 2, 2'd1, 2'd0, 1, 0}; // LDI, both phases late
        tbl[17] = '{16'h4000, 3'b111, 0, 0, 2'd3, 2'd3, 0, 0}; // JSR -> NOP

        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {24'b0, out_word()}, {24'b0, W_IDLE});
        check("reset_retired", {28'b0, instr_retired}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("idle_after_first_release", {24'b0, out_word()}, {24'b0, W_IDLE});

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i, 0);

        // Abort an LD while it waits in the read phase
        IR = 16'h2205; psr = 3'b010; iwait = 0; dwait = 50;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clock); #1;
            if (mem_state == 2'd0) found = 1'b1;
        end
        check("reach_mem_rd", {31'b0, found}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_abort", {24'b0, out_word()}, {24'b0, W_IDLE});
        exp_ret = '0;
        check("abort_retired", {28'b0, instr_retired}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("held_in_reset", {24'b0, out_word()}, {24'b0, W_IDLE});
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("idle_after_release", {24'b0, out_word()}, {24'b0, W_IDLE});

        // Recovery ADD plus nine more gives ten retirements
        for (int i = 0; i < 10; i++) run_vec(tbl[0], 100 + i, 0);
        @(posedge clock); #1;
        check("fetch_after_ten", {24'b0, out_word()}, {24'b0, W_F});
`ifdef LC3_CTRL_PERF_EN
        check("retired_ten", {28'b0, instr_retired}, 32'd10);
`endif
        run_vec(tbl[0], 200, 1);
        for (int i = 1; i < 6; i++) run_vec(tbl[0], 200 + i, 0);
        @(posedge clock); #1;
        check("fetch_after_wrap", {24'b0, out_word()}, {24'b0, W_F});
`ifdef LC3_CTRL_PERF_EN
        check("retired_wrap", {28'b0, instr_retired}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
